alu_multiciclo: RTL and testbench

//  Registered, parametrised ALU for the datapath's multi-cycle execute stage.

---
 rtl/alu_multiciclo.sv | 180 ++++++++++++++++++
 tb/tb_alu_multiciclo.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multiciclo.sv
// Registered multi-cycle ALU: single-cycle logic/arith ops plus iterative
// unsigned multiply (shift-add) and divide (restoring) with a start/busy/done handshake.
module alu_multiciclo #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [3:0]       selOp,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] resultado,
  output logic [WIDTH-1:0] resultadoHi,
  output logic             zeroFlag,
  output logic             divZero
);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_MULTU = 4'b1000;
  localparam logic [3:0] OP_DIVU  = 4'b1001;

  // Counter preloads to all-ones so WIDTH steps run at -1..WIDTH-2 and the
  // WIDTH-1 cycle is the write-back into the output registers.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXEC = 3'd1,
    S_MUL  = 3'd2,
    S_DIV  = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  state_t           state_r, state_s;
  logic [3:0]       sel_r;
  logic [WIDTH-1:0] a_r, b_r, hi_r, lo_r;
  logic [CNT_W-1:0] cnt_r;
  logic             accept_s, iter_s, wb_s;
  logic [WIDTH:0]   madd_s, dtrial_s;
  logic [WIDTH-1:0] exec_res_s, exec_hi_s;
  logic             exec_upd_s, exec_dz_s;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= S_IDLE;
    else        state_r <= state_s;
  end

  // Next-state logic and datapath strobes
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    iter_s   = 1'b0;
    wb_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          accept_s = 1'b1;
          if (selOp == OP_MULTU)                                state_s = S_MUL;
          else if (selOp == OP_DIVU && op2 != {WIDTH{1'b0}})    state_s = S_DIV;
          else                                                  state_s = S_EXEC;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_EXEC: state_s = S_FIN;
      S_MUL, S_DIV: begin
        if (cnt_r == CNT_LAST) begin
          wb_s    = 1'b1;
          state_s = S_FIN;
        end else begin
          iter_s  = 1'b1;
        end
      end
      S_FIN:   state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Shift-add partial sum and restoring-division trial subtraction
  always_comb begin
    madd_s   = {1'b0, hi_r} + ({(WIDTH+1){lo_r[0]}} & {1'b0, a_r});
    dtrial_s = {hi_r, lo_r[WIDTH-1]} - {1'b0, b_r};
  end

  // Single-cycle op results; unknown codes leave the outputs untouched
  always_comb begin
    exec_upd_s = 1'b1;
    exec_res_s = {WIDTH{1'b0}};
    exec_hi_s  = {WIDTH{1'b0}};
    exec_dz_s  = 1'b0;
    case (sel_r)
      OP_AND:  exec_res_s = a_r & b_r;
      OP_OR:   exec_res_s = a_r | b_r;
      OP_ADD:  exec_res_s = a_r + b_r;
      OP_SUB:  exec_res_s = a_r - b_r;
      OP_SLT:  exec_res_s = {{(WIDTH-1){1'b0}}, (a_r < b_r)};
      OP_NOR:  exec_res_s = ~(a_r | b_r);
      OP_DIVU: begin
        exec_res_s = {WIDTH{1'b1}};
        exec_hi_s  = a_r;
        exec_dz_s  = 1'b1;
      end
      default: exec_upd_s = 1'b0;
    endcase
  end

  // Operand capture and iterative multiply/divide registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_r <= 4'b0000;
      a_r   <= {WIDTH{1'b0}};
      b_r   <= {WIDTH{1'b0}};
      hi_r  <= {WIDTH{1'b0}};
      lo_r  <= {WIDTH{1'b0}};
      cnt_r <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      sel_r <= selOp;
      a_r   <= op1;
      b_r   <= op2;
      hi_r  <= {WIDTH{1'b0}};
      lo_r  <= (selOp == OP_MULTU) ? op2 : op1;
      cnt_r <= CNT_PRE;
    end else if (iter_s) begin
      cnt_r <= cnt_r + CNT_ONE;
      if (state_r == S_MUL) begin
        hi_r <= madd_s[WIDTH:1];
        lo_r <= {madd_s[0], lo_r[WIDTH-1:1]};
      end else if (!dtrial_s[WIDTH]) begin
        hi_r <= dtrial_s[WIDTH-1:0];
        lo_r <= {lo_r[WIDTH-2:0], 1'b1};
      end else begin
        hi_r <= {hi_r[WIDTH-2:0], lo_r[WIDTH-1]};
        lo_r <= {lo_r[WIDTH-2:0], 1'b0};
      end
    end
  end

  // Registered outputs: written only on the edge into FIN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      resultado   <= {WIDTH{1'b0}};
      resultadoHi <= {WIDTH{1'b0}};
      zeroFlag    <= 1'b0;
      divZero     <= 1'b0;
    end else begin
      busy <= (state_s == S_EXEC) || (state_s == S_MUL) || (state_s == S_DIV);
      if (state_r == S_EXEC) begin
        done    <= 1'b1;
        divZero <= exec_dz_s;
        if (exec_upd_s) begin
          resultado   <= exec_res_s;
          resultadoHi <= exec_hi_s;
          zeroFlag    <= (exec_res_s == {WIDTH{1'b0}});
        end
      end else if (wb_s) begin
        done        <= 1'b1;
        divZero     <= 1'b0;
        resultado   <= lo_r;
        resultadoHi <= hi_r;
        zeroFlag    <= (lo_r == {WIDTH{1'b0}});
      end else begin
        done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_multiciclo.sv
// Scoreboard bench for alu_multiciclo at WIDTH=32 and WIDTH=8 with an
// arithmetic reference model and a decoupled done-driven monitor.
module tb_alu_multiciclo;

  localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010,
                         OP_SUB = 4'b0110, OP_SLT = 4'b0111, OP_NOR = 4'b1100,
                         OP_MUL = 4'b1000, OP_DIV = 4'b1001, OP_UND = 4'b0011;

  typedef struct {
    logic [31:0] res;
    logic [31:0] hi;
    logic        zf;
    logic        dz;
    int          lat;
    int          t0;
  } exp_t;

  logic clk, rst_n;
  logic start_a, start_b;
  logic [31:0] op1_a, op2_a;
  logic [7:0]  op1_b, op2_b;
  logic [3:0]  sel_a, sel_b;
  logic busy_a, done_a, zf_a, dz_a, busy_b, done_b, zf_b, dz_b;
  logic [31:0] res_a, hi_a;
  logic [7:0]  res_b, hi_b;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  exp_t q32[$];
  exp_t q8[$];
  logic [31:0] last_res[2];
  logic [31:0] last_hi[2];
  logic        last_zf[2];

  alu_multiciclo #(.WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n), .start(start_a), .op1(op1_a), .op2(op2_a), .selOp(sel_a),
    .busy(busy_a), .done(done_a), .resultado(res_a), .resultadoHi(hi_a),
    .zeroFlag(zf_a), .divZero(dz_a));

  alu_multiciclo #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start_b), .op1(op1_b), .op2(op2_b), .selOp(sel_b),
    .busy(busy_b), .done(done_b), .resultado(res_b), .resultadoHi(hi_b),
    .zeroFlag(zf_b), .divZero(dz_b));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic dut_busy(input int w);
    return (w == 32) ? busy_a : busy_b;
  endfunction

  function automatic logic dut_done(input int w);
    return (w == 32) ? done_a : done_b;
  endfunction

  task automatic drive(input int w, input logic s, input logic [3:0] sel,
                       input logic [31:0] a, input logic [31:0] b);
    if (w == 32) begin
      start_a = s; sel_a = sel; op1_a = a; op2_a = b;
    end else begin
      start_b = s; sel_b = sel; op1_b = a[7:0]; op2_b = b[7:0];
    end
  endtask

  // Reference model: plain arithmetic on the masked operands
  task automatic push_exp(input int w, input logic [3:0] sel,
                          input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [63:0] m, av, bv, p, r, h;
    logic upd;
    int k;
    k   = (w == 32) ? 0 : 1;
    m   = (64'd1 << w) - 64'd1;
    av  = {32'd0, a} & m;
    bv  = {32'd0, b} & m;
    r   = 64'd0;
    h   = 64'd0;
    upd = 1'b1;
    e.dz  = 1'b0;
    e.lat = 2;
    e.t0  = cyc;
    case (sel)
      OP_AND: r = av & bv;
      OP_OR:  r = av | bv;
      OP_ADD: r = (av + bv) & m;
      OP_SUB: r = (av - bv) & m;
      OP_SLT: r = (av < bv) ? 64'd1 : 64'd0;
      OP_NOR: r = ~(av | bv) & m;
      OP_MUL: begin
        p = av * bv; r = p & m; h = p >> w; e.lat = w + 2;
      end
      OP_DIV: begin
        if (bv == 64'd0) begin
          r = m; h = av; e.dz = 1'b1;
        end else begin
          r = av / bv; h = av % bv; e.lat = w + 2;
        end
      end
      default: upd = 1'b0;
    endcase
    if (upd) begin
      last_res[k] = r[31:0];
      last_hi[k]  = h[31:0];
      last_zf[k]  = (r == 64'd0);
    end
    e.res = last_res[k];
    e.hi  = last_hi[k];
    e.zf  = last_zf[k];
    if (w == 32) q32.push_back(e);
    else         q8.push_back(e);
  endtask

  task automatic check_done(input int w);
    exp_t e;
    if ((w == 32 && q32.size() == 0) || (w == 8 && q8.size() == 0)) begin
      chk($sformatf("w%0d_unexpected_done", w), 64'd1, 64'd0);
    end else begin
      if (w == 32) begin
        e = q32.pop_front();
        chk("w32_resultado", {32'd0, res_a}, {32'd0, e.res});
        chk("w32_resultadoHi", {32'd0, hi_a}, {32'd0, e.hi});
        chk("w32_zeroFlag", {63'd0, zf_a}, {63'd0, e.zf});
        chk("w32_divZero", {63'd0, dz_a}, {63'd0, e.dz});
      end else begin
        e = q8.pop_front();
        chk("w8_resultado", {56'd0, res_b}, {32'd0, e.res});
        chk("w8_resultadoHi", {56'd0, hi_b}, {32'd0, e.hi});
        chk("w8_zeroFlag", {63'd0, zf_b}, {63'd0, e.zf});
        chk("w8_divZero", {63'd0, dz_b}, {63'd0, e.dz});
      end
      chk($sformatf("w%0d_latency", w), 64'(cyc - e.t0), 64'(e.lat));
    end
  endtask

  // Monitor: compares every done pulse against the scoreboard head
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done_a === 1'b1) check_done(32);
    if (rst_n === 1'b1 && done_b === 1'b1) check_done(8);
  end

  // Called at a negedge: presents start for one cycle, then scrambles operands
  task automatic launch(input int w, input logic [3:0] sel,
                        input logic [31:0] a, input logic [31:0] b);
    push_exp(w, sel, a, b);
    drive(w, 1'b1, sel, a, b);
    @(negedge clk);
    drive(w, 1'b0, ~sel, ~a, ~b);
  endtask

  task automatic wait_done(input int w);
    int n = 0;
    while (dut_done(w) !== 1'b1 && n < 200) begin
      chk($sformatf("w%0d_busy_running", w), {63'd0, dut_busy(w)}, 64'd1);
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk($sformatf("w%0d_done_timeout", w), 64'd0, 64'd1);
    else          chk($sformatf("w%0d_busy_at_done", w), {63'd0, dut_busy(w)}, 64'd0);
  endtask

  task automatic run(input int w, input logic [3:0] sel,
                     input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    launch(w, sel, a, b);
    wait_done(w);
  endtask

  task automatic rand_op(input int w);
    logic [3:0] codes [16];
    logic [3:0] sel;
    logic [31:0] a, b;
    int pick;
    codes = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_MUL, OP_DIV,
              OP_MUL, OP_DIV, OP_ADD, OP_SUB, OP_UND, 4'b0100, 4'b1010, 4'b1111};
    pick = $urandom_range(15, 0);
    sel  = codes[pick];
    a    = $urandom;
    b    = $urandom;
    case ($urandom_range(5, 0))
      0: b = 32'd0;
      1: a = 32'hFFFF_FFFF;
      2: b = 32'hFFFF_FFFF;
      3: a = b;
      default: ;
    endcase
    run(w, sel, a, b);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_busy_a"}, {63'd0, busy_a}, 64'd0);
    chk({tag, "_done_a"}, {63'd0, done_a}, 64'd0);
    chk({tag, "_res_a"}, {32'd0, res_a}, 64'd0);
    chk({tag, "_hi_a"}, {32'd0, hi_a}, 64'd0);
    chk({tag, "_zf_a"}, {63'd0, zf_a}, 64'd0);
    chk({tag, "_dz_a"}, {63'd0, dz_a}, 64'd0);
    chk({tag, "_res_b"}, {56'd0, res_b}, 64'd0);
    chk({tag, "_busy_b"}, {63'd0, busy_b}, 64'd0);
  endtask

  task automatic clear_model();
    for (int k = 0; k < 2; k++) begin
      last_res[k] = 32'd0;
      last_hi[k]  = 32'd0;
      last_zf[k]  = 1'b0;
    end
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b1;
    drive(32, 1'b0, OP_AND, 32'd0, 32'd0);
    drive(8, 1'b0, OP_AND, 32'd0, 32'd0);
    clear_model();
    #1 rst_n = 1'b0;
    #1 reset_checks("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=32 directed corners
    run(32, OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001);
    run(32, OP_SUB, 32'd5, 32'd7);
    run(32, OP_SLT, 32'd1, 32'hFFFF_FFFF);
    run(32, OP_SLT, 32'hFFFF_FFFF, 32'd1);
    run(32, OP_NOR, 32'h0F0F_0000, 32'h0000_00FF);
    run(32, OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(32, OP_DIV, 32'd100, 32'd7);
    run(32, OP_DIV, 32'd9, 32'd0);
    run(32, OP_ADD, 32'h50, 32'h05);
    run(32, OP_UND, 32'h1234, 32'h9999);

    // Start during busy is ignored
    @(negedge clk);
    launch(32, OP_MUL, 32'h0000_1234, 32'h0000_0100);
    repeat (5) @(negedge clk);
    drive(32, 1'b1, OP_ADD, 32'hDEAD, 32'hBEEF);
    @(negedge clk);
    drive(32, 1'b0, OP_ADD, 32'hDEAD, 32'hBEEF);
    wait_done(32);
    // Start in the done cycle is ignored; start in the next cycle is taken
    drive(32, 1'b1, OP_SUB, 32'd9, 32'd1);
    @(negedge clk);
    launch(32, OP_OR, 32'hF0F0_0000, 32'h0000_0F0F);
    wait_done(32);

    // Reset in the middle of a MULTU
    @(negedge clk);
    drive(32, 1'b1, OP_MUL, 32'h1234_5678, 32'h0000_0777);
    @(negedge clk);
    drive(32, 1'b0, OP_AND, 32'd0, 32'd0);
    repeat (9) @(negedge clk);
    chk("busy_before_reset", {63'd0, busy_a}, 64'd1);
    rst_n = 1'b0;
    #1 reset_checks("midop");
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    repeat (45) @(negedge clk);

    // WIDTH=8 directed corners
    run(8, OP_ADD, 32'hFF, 32'h01);
    run(8, OP_SUB, 32'd5, 32'd7);
    run(8, OP_SLT, 32'd1, 32'hFF);
    run(8, OP_MUL, 32'hFF, 32'hFF);
    run(8, OP_DIV, 32'd100, 32'd7);
    run(8, OP_DIV, 32'd9, 32'd0);
    run(8, OP_UND, 32'd3, 32'd4);

    for (int i = 0; i < 40; i++) rand_op(8);
    for (int i = 0; i < 25; i++) rand_op(32);

    repeat (4) @(negedge clk);
    chk("q32_drained", 64'(q32.size()), 64'd0);
    chk("q8_drained", 64'(q8.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
